// File: rtl/fp_exe_issue_pkg.sv
// Shared types for the FP issue block: fp_unit interface records, the queued
// request record, the issue FSM state and the issue register bundle.
package fp_exe_issue_pkg;

  localparam int FP_ISSUE_TAG_W   = 4;
  localparam int FP_ISSUE_TIMER_W = 16;

  typedef struct packed {
    logic       fmadd;
    logic       fmsub;
    logic       fnmsub;
    logic       fnmadd;
    logic       fadd;
    logic       fsub;
    logic       fmul;
    logic       fdiv;
    logic       fsqrt;
    logic       fsgnj;
    logic       fcmp;
    logic       fmax;
    logic       fclass;
    logic       fmv_i2f;
    logic       fmv_f2i;
    logic       fcvt_i2f;
    logic       fcvt_f2i;
    logic [1:0] fcvt_op;
  } fp_operation_type;

  localparam fp_operation_type init_fp_operation = '0;

  typedef struct packed {
    logic [63:0]      data1;
    logic [63:0]      data2;
    logic [63:0]      data3;
    fp_operation_type op;
    logic [1:0]       fmt;
    logic [2:0]       rm;
    logic             enable;
  } fp_exe_in_type;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  flags;
    logic        ready;
  } fp_exe_out_type;

  typedef struct packed {
    logic [63:0]               data1;
    logic [63:0]               data2;
    logic [63:0]               data3;
    fp_operation_type          op;
    logic [1:0]                fmt;
    logic [2:0]                rm;
    logic [FP_ISSUE_TAG_W-1:0] tag;
  } fp_issue_req_type;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_DRAIN
  } fp_issue_state_type;

  typedef struct packed {
    fp_issue_state_type          state;
    fp_issue_req_type            opr;
    logic [FP_ISSUE_TIMER_W-1:0] timer;
    logic [63:0]                 result;
    logic [4:0]                  flags;
    logic                        err;
    logic [4:0]                  fflags;
  } fp_issue_reg_type;

  localparam fp_issue_reg_type init_fp_issue_reg = '{
    state:  ST_IDLE,
    opr:    '0,
    timer:  '0,
    result: '0,
    flags:  '0,
    err:    1'b0,
    fflags: '0
  };

endpackage

// File: rtl/fp_exe_issue_fifo.sv
// Request queue for the FP issue block: synchronous FIFO with occupancy count
// and a flush that empties it in one cycle.
module fp_issue_fifo
  import fp_exe_issue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  fp_issue_req_type             push_data,
  input  logic                         pop,
  output fp_issue_req_type             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fp_issue_req_type mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush && (count < DEPTH_C);
  assign do_pop  = pop && !flush && (count != '0);
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fp_exe_issue.sv
// Requester end of the fp_unit interface: queues FP requests, issues them one
// at a time with a one-cycle enable, waits for ready (or times out), returns
// result/flags/tag over a valid/ready channel and keeps sticky fflags.
module fp_exe_issue
  import fp_exe_issue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255,
  parameter int TAG_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  fp_issue_req_type req_data,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [63:0]      resp_result,
  output logic [4:0]       resp_flags,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err,
  input  logic             flush,
  output logic [4:0]       fflags,
  input  logic             fflags_clr,
  output fp_exe_in_type    fp_exe_i,
  input  fp_exe_out_type   fp_exe_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [FP_ISSUE_TIMER_W-1:0] TMO_LAST = FP_ISSUE_TIMER_W'(TIMEOUT - 1);

  fp_issue_reg_type r;
  fp_issue_reg_type v;
  fp_issue_req_type fifo_head;
  logic [CW-1:0]    fifo_count;
  logic             fifo_pop;
  logic             fifo_push;

  assign req_ready = (fifo_count < DEPTH_C);
  assign fifo_push = req_valid && req_ready && !flush;

  fp_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (fifo_push),
    .push_data (req_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // Next-state, capture and sticky-flag logic for the issue FSM.
  always_comb begin
    v        = r;
    fifo_pop = 1'b0;
    if (fflags_clr) v.fflags = '0;
    case (r.state)
      ST_IDLE: begin
        if (fifo_count != '0) begin
          fifo_pop = 1'b1;
          v.opr    = fifo_head;
          v.timer  = '0;
          v.state  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        v.timer = r.timer + FP_ISSUE_TIMER_W'(1);
        if (fp_exe_o.ready) begin
          v.result = fp_exe_o.result;
          v.flags  = fp_exe_o.flags;
          v.err    = 1'b0;
          v.state  = ST_RESP;
        end else begin
          v.state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        v.timer = r.timer + FP_ISSUE_TIMER_W'(1);
        if (fp_exe_o.ready) begin
          v.result = fp_exe_o.result;
          v.flags  = fp_exe_o.flags;
          v.err    = 1'b0;
          v.state  = ST_RESP;
        end else if (r.timer >= TMO_LAST) begin
          v.result = '0;
          v.flags  = '0;
          v.err    = 1'b1;
          v.state  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          v.fflags = v.fflags | r.flags;
          v.state  = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        v.timer = r.timer + FP_ISSUE_TIMER_W'(1);
        if (fp_exe_o.ready || (r.timer >= TMO_LAST)) v.state = ST_IDLE;
      end
      default: v.state = ST_IDLE;
    endcase
    // Flush overrides the case above: undo any pop/capture/accumulate, then
    // steer the FSM. An op already at the unit must still be drained.
    if (flush) begin
      fifo_pop = 1'b0;
      v.opr    = r.opr;
      v.result = r.result;
      v.flags  = r.flags;
      v.err    = r.err;
      v.fflags = fflags_clr ? '0 : r.fflags;
      if (r.state == ST_ISSUE || r.state == ST_WAIT) begin
        v.state = ST_DRAIN;
      end else if (r.state != ST_DRAIN) begin
        v.state = ST_IDLE;
        v.timer = r.timer;
      end
    end
  end

  // Issue register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) r <= init_fp_issue_reg;
    else       r <= v;
  end

  // Request to fp_unit is driven straight from the op register.
  always_comb begin
    fp_exe_i        = '0;
    fp_exe_i.data1  = r.opr.data1;
    fp_exe_i.data2  = r.opr.data2;
    fp_exe_i.data3  = r.opr.data3;
    fp_exe_i.op     = r.opr.op;
    fp_exe_i.fmt    = r.opr.fmt;
    fp_exe_i.rm     = r.opr.rm;
    fp_exe_i.enable = (r.state == ST_ISSUE);
  end

  assign resp_valid  = (r.state == ST_RESP);
  assign resp_result = r.result;
  assign resp_flags  = r.flags;
  assign resp_tag    = TAG_W'(r.opr.tag);
  assign resp_err    = r.err;
  assign fflags      = r.fflags;

endmodule

// File: tb/tb_fp_exe_issue.sv
// Directed bench for fp_exe_issue with a small behavioural fp_unit that
// answers data1+data2 with flags data3[4:0] a programmable number of cycles
// after each enable pulse (unit_lat <= 0 means it never answers).
module tb_fp_exe_issue;
  import fp_exe_issue_pkg::*;

  logic             clock;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  fp_issue_req_type req_data;
  logic             resp_valid;
  logic             resp_ready;
  logic [63:0]      resp_result;
  logic [4:0]       resp_flags;
  logic [3:0]       resp_tag;
  logic             resp_err;
  logic             flush;
  logic [4:0]       fflags;
  logic             fflags_clr;
  fp_exe_in_type    fp_exe_i;
  fp_exe_out_type   fp_exe_o;

  fp_exe_issue #(.DEPTH(4), .TIMEOUT(8), .TAG_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_flags  (resp_flags),
    .resp_tag    (resp_tag),
    .resp_err    (resp_err),
    .flush       (flush),
    .fflags      (fflags),
    .fflags_clr  (fflags_clr),
    .fp_exe_i    (fp_exe_i),
    .fp_exe_o    (fp_exe_o)
  );

  typedef struct {
    logic [63:0] d1;
    logic [63:0] d2;
    logic [4:0]  fl;
    logic [3:0]  tag;
    logic [63:0] exp_res;
    logic [4:0]  exp_fl;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  fl;
    logic [3:0]  tag;
    logic        err;
  } resp_t;

  int    n_checks = 0;
  int    n_err = 0;
  int    unit_lat = 1;
  logic  unit_armed = 1'b0;
  int    unit_cnt = 0;
  logic [63:0] unit_res = '0;
  logic [4:0]  unit_fl = '0;
  int    enable_count = 0;
  int    overlap_count = 0;
  int    valid_cycles = 0;
  resp_t resp_q[$];
  vec_t  vecs[6];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural fp_unit: arm on enable, raise ready unit_lat cycles later.
  always @(negedge clock) begin
    if (fp_exe_i.enable && unit_lat > 0) begin
      unit_armed <= 1'b1;
      unit_cnt   <= unit_lat;
      unit_res   <= fp_exe_i.data1 + fp_exe_i.data2;
      unit_fl    <= fp_exe_i.data3[4:0];
    end else if (unit_armed) begin
      if (unit_cnt == 0) unit_armed <= 1'b0;
      else               unit_cnt   <= unit_cnt - 1;
    end
  end

  // Unit outputs; result carries junk whenever ready is low.
  always_comb begin
    fp_exe_o.ready  = unit_armed && (unit_cnt == 0);
    fp_exe_o.result = fp_exe_o.ready ? unit_res : 64'hDEAD_BEEF_DEAD_BEEF;
    fp_exe_o.flags  = fp_exe_o.ready ? unit_fl : 5'h1F;
  end

  // Observe enables, overlaps and completed response handshakes.
  always @(negedge clock) begin
    if (fp_exe_i.enable) enable_count <= enable_count + 1;
    if (fp_exe_i.enable && resp_valid) overlap_count <= overlap_count + 1;
    if (resp_valid) valid_cycles <= valid_cycles + 1;
    if (resp_valid && resp_ready && !flush && !reset)
      resp_q.push_back('{res: resp_result, fl: resp_flags, tag: resp_tag, err: resp_err});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit, required self-termination");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic fp_issue_req_type make_req(input logic [63:0] d1, input logic [63:0] d2,
                                                input logic [4:0] fl, input logic [3:0] tag);
    fp_issue_req_type q;
    q          = '0;
    q.data1    = d1;
    q.data2    = d2;
    q.data3    = {59'd0, fl};
    q.op.fadd  = 1'b1;
    q.fmt      = 2'b01;
    q.tag      = tag;
    return q;
  endfunction

  task automatic push_req(input string name, input fp_issue_req_type q);
    int n = 0;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    check(name, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_data  = q;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!resp_valid && n < 50) begin
      step();
      n++;
    end
    check(name, 64'(resp_valid), 64'd1);
  endtask

  task automatic wait_enable(input string name);
    int n = 0;
    while (!fp_exe_i.enable && n < 50) begin
      step();
      n++;
    end
    check(name, 64'(fp_exe_i.enable), 64'd1);
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_resp_valid"},  64'(resp_valid),  64'd0);
    check({pfx, "_resp_result"}, resp_result,      64'd0);
    check({pfx, "_resp_flags"},  64'(resp_flags),  64'd0);
    check({pfx, "_resp_tag"},    64'(resp_tag),    64'd0);
    check({pfx, "_resp_err"},    64'(resp_err),    64'd0);
    check({pfx, "_fflags"},      64'(fflags),      64'd0);
    check({pfx, "_exe_i_zero"},  64'(fp_exe_i == '0), 64'd1);
  endtask

  initial begin
    int e0, ov0, vc0, n, bad;

    vecs[0] = '{64'h10, 64'h5, 5'h01, 4'd0, 64'h15, 5'h01};
    vecs[1] = '{64'h100, 64'h200, 5'h02, 4'd1, 64'h300, 5'h02};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 5'h04, 4'd2, 64'h0, 5'h04};
    vecs[3] = '{64'h1234_0000_0000_0000, 64'h5678, 5'h08, 4'd3, 64'h1234_0000_0000_5678, 5'h08};
    vecs[4] = '{64'h7, 64'h8, 5'h10, 4'd4, 64'hF, 5'h10};
    vecs[5] = '{64'h40, 64'h2, 5'h00, 4'd5, 64'h42, 5'h00};

    reset = 1'b1; req_valid = 1'b0; req_data = '0; resp_ready = 1'b0;
    flush = 1'b0; fflags_clr = 1'b0;
    step(); step();
    check_reset_state("rst");
    reset = 1'b0;
    step();
    check("rst_req_ready", 64'(req_ready), 64'd1);

    // Test 1: single fadd, unit ready 3 cycles after enable.
    unit_lat = 3;
    e0 = enable_count;
    req_valid = 1'b1; req_data = make_req(64'd3, 64'd4, 5'b00101, 4'hA);
    step();
    req_valid = 1'b0;
    check("t1_no_enable_at_pop", 64'(fp_exe_i.enable), 64'd0);
    step();
    check("t1_enable_at_n2", 64'(fp_exe_i.enable), 64'd1);
    check("t1_exe_data1", fp_exe_i.data1, 64'd3);
    n = 0;
    do begin
      step();
      n++;
    end while (!resp_valid && n < 20);
    check("t1_latency", 64'(n), 64'd4);
    check("t1_result", resp_result, 64'd7);
    check("t1_flags", 64'(resp_flags), 64'h05);
    check("t1_tag", 64'(resp_tag), 64'hA);
    check("t1_err", 64'(resp_err), 64'd0);
    check("t1_one_enable", 64'(enable_count - e0), 64'd1);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("t1_fflags", 64'(fflags), 64'h05);
    check("t1_valid_drop", 64'(resp_valid), 64'd0);

    // Test 2: six back-to-back requests, unit ready after 1 cycle.
    resp_q.delete();
    e0 = enable_count; ov0 = overlap_count;
    unit_lat = 1;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_data  = make_req(vecs[i].d1, vecs[i].d2, vecs[i].fl, vecs[i].tag);
      step();
    end
    req_valid = 1'b0;
    check("t2_full_req_ready", 64'(req_ready), 64'd0);
    resp_ready = 1'b1;
    push_req("t2_push5_ready", make_req(vecs[5].d1, vecs[5].d2, vecs[5].fl, vecs[5].tag));
    n = 0;
    while (resp_q.size() < 6 && n < 100) begin
      step();
      n++;
    end
    check("t2_resp_count", 64'(resp_q.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < resp_q.size()) begin
        check($sformatf("t2_result%0d", i), resp_q[i].res, vecs[i].exp_res);
        check($sformatf("t2_flags%0d", i), 64'(resp_q[i].fl), 64'(vecs[i].exp_fl));
        check($sformatf("t2_tag%0d", i), 64'(resp_q[i].tag), 64'(vecs[i].tag));
        check($sformatf("t2_err%0d", i), 64'(resp_q[i].err), 64'd0);
      end
    end
    check("t2_enables", 64'(enable_count - e0), 64'd6);
    check("t2_no_overlap", 64'(overlap_count - ov0), 64'd0);
    check("t2_fflags", 64'(fflags), 64'h1F);
    resp_ready = 1'b0;

    // Test 3: response held 10 cycles with another op queued behind it.
    unit_lat = 2;
    push_req("t3_push_a", make_req(64'h11, 64'h22, 5'h02, 4'd6));
    push_req("t3_push_b", make_req(64'h1, 64'h1, 5'h04, 4'd7));
    wait_valid("t3_first_valid");
    e0 = enable_count;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!resp_valid || resp_result !== 64'h33 || resp_tag !== 4'd6 || resp_flags !== 5'h02) bad++;
      step();
    end
    check("t3_held_stable", 64'(bad), 64'd0);
    check("t3_no_enable_held", 64'(enable_count - e0), 64'd0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    wait_valid("t3_second_valid");
    check("t3_second_tag", 64'(resp_tag), 64'd7);
    check("t3_second_result", resp_result, 64'h2);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;

    // Test 4: unit never answers, TIMEOUT=8; the next op then issues.
    unit_lat = 0;
    push_req("t4_push_a", make_req(64'h5, 64'h6, 5'h01, 4'd8));
    push_req("t4_push_b", make_req(64'h20, 64'h1, 5'h08, 4'd9));
    wait_enable("t4_enable");
    step();
    n = 1;
    unit_lat = 1;
    while (!resp_valid && n < 30) begin
      step();
      n++;
    end
    check("t4_timeout_latency", 64'(n), 64'd8);
    check("t4_err", 64'(resp_err), 64'd1);
    check("t4_result_zero", resp_result, 64'd0);
    check("t4_flags_zero", 64'(resp_flags), 64'd0);
    check("t4_tag", 64'(resp_tag), 64'd8);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    wait_valid("t4_next_valid");
    check("t4_next_tag", 64'(resp_tag), 64'd9);
    check("t4_next_err", 64'(resp_err), 64'd0);
    check("t4_next_result", resp_result, 64'h21);
    resp_ready = 1'b1;
    step();

    // Test 5: flush in WAIT with three queued ops, ready two cycles later.
    unit_lat = 4;
    resp_q.delete();
    e0 = enable_count; vc0 = valid_cycles;
    push_req("t5_push0", make_req(64'h1, 64'h1, 5'h01, 4'hB));
    push_req("t5_push1", make_req(64'h2, 64'h2, 5'h01, 4'hC));
    push_req("t5_push2", make_req(64'h3, 64'h3, 5'h01, 4'hD));
    push_req("t5_push3", make_req(64'h4, 64'h4, 5'h01, 4'hE));
    check("t5_one_issued", 64'(enable_count - e0), 64'd1);
    flush = 1'b1;
    req_valid = 1'b1; req_data = make_req(64'h9, 64'h9, 5'h01, 4'hF);
    step();
    flush = 1'b0; req_valid = 1'b0;
    check("t5_req_ready", 64'(req_ready), 64'd1);
    e0 = enable_count;
    for (int i = 0; i < 8; i++) step();
    check("t5_no_enable", 64'(enable_count - e0), 64'd0);
    check("t5_no_valid", 64'(valid_cycles - vc0), 64'd0);
    check("t5_no_resp", 64'(resp_q.size()), 64'd0);
    unit_lat = 1;
    push_req("t5_push_new", make_req(64'h100, 64'h1, 5'h00, 4'd3));
    check("t5_idle_pop", 64'(fp_exe_i.enable), 64'd0);
    step();
    check("t5_idle_enable", 64'(fp_exe_i.enable), 64'd1);
    wait_valid("t5_new_valid");
    check("t5_new_tag", 64'(resp_tag), 64'd3);
    check("t5_new_result", resp_result, 64'h101);
    step();
    resp_ready = 1'b0;

    // Test 6: fflags clear/handshake interplay, then reset while in WAIT.
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    check("t6_clr_alone", 64'(fflags), 64'd0);
    unit_lat = 1;
    push_req("t6_push_a", make_req(64'h1, 64'h1, 5'b00001, 4'd1));
    wait_valid("t6_valid_a");
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("t6_fflags_01", 64'(fflags), 64'h01);
    push_req("t6_push_b", make_req(64'h2, 64'h2, 5'b10000, 4'd2));
    wait_valid("t6_valid_b");
    resp_ready = 1'b1; fflags_clr = 1'b1;
    step();
    resp_ready = 1'b0; fflags_clr = 1'b0;
    check("t6_clr_with_hs", 64'(fflags), 64'h10);
    unit_lat = 5;
    push_req("t6_push_c", make_req(64'hAAAA, 64'h5555, 5'h01, 4'd4));
    wait_enable("t6_enable_c");
    step(); step();
    check("t6_wait_data1", fp_exe_i.data1, 64'hAAAA);
    reset = 1'b1;
    step();
    check_reset_state("t6_rst");
    check("t6_rst_req_ready", 64'(req_ready), 64'd1);
    reset = 1'b0;
    e0 = enable_count; vc0 = valid_cycles;
    for (int i = 0; i < 10; i++) step();
    check("t6_late_ready_ignored", 64'(valid_cycles - vc0), 64'd0);
    check("t6_no_enable_after_rst", 64'(enable_count - e0), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
